// File: rtl/fir_pkg.sv
// Shared constants and round/shift/saturate helpers for the FIR output stage.
// The helpers work on 64-bit signed values so any ACC_W up to 63 fits without wrap.
package fir_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SHIFT_DEF = 15;
    localparam int ACC_W_DEF = 2 * WIDTH_DEF + 6;

    function automatic longint SAT_MAX(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint SAT_MIN(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    // Round half toward +infinity, then arithmetic shift right.
    function automatic longint round_shift(input longint acc, input int shift);
        if (shift == 0) begin
            return acc;
        end
        return (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    endfunction

    function automatic longint round_sat(input longint acc, input int width, input int shift);
        longint r;
        r = round_shift(acc, shift);
        if (r > SAT_MAX(width)) begin
            return SAT_MAX(width);
        end
        if (r < SAT_MIN(width)) begin
            return SAT_MIN(width);
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through circular FIFO; head word is always visible on rd_data.
// Pointers carry one extra bit so full and empty are distinguishable.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    assign level    = wr_ptr_q - rd_ptr_q;
    assign rd_valid = (level != '0);
    assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        // Pop on empty is silently ignored.
        if (pop && rd_valid) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/fir_output_stage.sv
// FIR result consumer: round, shift and saturate the accumulator, stage it for one
// cycle, then buffer it in a FWFT FIFO with sticky saturation and drop reporting.
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ACC_W = 2 * WIDTH + 6,
    parameter int SHIFT = SHIFT_DEF,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [ACC_W-1:0]         in_acc,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     clr_flags,
    output logic                     sat_flag,
    output logic [7:0]               drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int LW = $clog2(DEPTH) + 1;

    longint            acc_ext;
    longint            rounded;
    longint            clipped;
    logic [WIDTH-1:0]  sat_val;
    logic              sat_hit;
    logic              accept;
    logic              drop;
    logic [LW:0]       occupancy;

    logic              stage_valid_q, stage_valid_d;
    logic [WIDTH-1:0]  stage_data_q, stage_data_d;
    logic              sat_flag_q, sat_flag_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    always_comb begin
        acc_ext = {{(64-ACC_W){in_acc[ACC_W-1]}}, in_acc};
        rounded = round_shift(acc_ext, SHIFT);
        clipped = round_sat(acc_ext, WIDTH, SHIFT);
        sat_val = clipped[WIDTH-1:0];
        sat_hit = (rounded != clipped);
    end

    // The stage entry counts against capacity so it can always drain next cycle.
    assign occupancy = {1'b0, level} + {{LW{1'b0}}, stage_valid_q};
    assign in_ready  = (occupancy < (LW+1)'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign drop      = in_valid && !in_ready;

    always_comb begin
        stage_valid_d = accept;
        stage_data_d  = stage_data_q;
        sat_flag_d    = sat_flag_q;
        drop_cnt_d    = drop_cnt_q;

        if (accept) begin
            stage_data_d = sat_val;
        end

        // Events win over a same-cycle clear.
        if (accept && sat_hit) begin
            sat_flag_d = 1'b1;
        end else if (clr_flags) begin
            sat_flag_d = 1'b0;
        end

        if (drop) begin
            if (clr_flags) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hff) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (clr_flags) begin
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            sat_flag_q    <= 1'b0;
            drop_cnt_q    <= 8'd0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            sat_flag_q    <= sat_flag_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign sat_flag = sat_flag_q;
    assign drop_cnt = drop_cnt_q;

    sync_fifo_fwft #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stage_valid_q),
        .push_data (stage_data_q),
        .pop       (out_ready),
        .rd_data   (out_data),
        .rd_valid  (out_valid),
        .level     (level)
    );

endmodule
